clk_monitor: RTL and testbench

Receive-side companion to the clock prescaler. It samples the divided clock (nominal 2.4576 MHz) in the 49.152 MHz domain and measures each half-period in clk cycles. It declares lock after consecutive in-tolerance half-periods and flags loss on a timeout or an out-of-tolerance half-period. Sits beside the prescaler and gates downstream logic that depends on the divided clock being alive and on-frequency.

---
 rtl/clk_mon_pkg.sv | 19 +
 rtl/clk_monitor_edge_sync.sv | 30 +++
 rtl/clk_monitor.sv | 177 +++++++++++++++++
 tb/tb_clk_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_mon_pkg;

   // Width of the saturating error counter.
   localparam int ERR_W = 8;

   // Monitor FSM states.
   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } clk_state_e;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

endpackage

// File: rtl/clk_monitor_edge_sync.sv
// Three-flop synchronizer with an any-edge detector on the synchronized level.
// The first two flops resolve metastability; the third holds the previous
// synchronized level so the XOR flags a change one cycle wide.
module edge_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_edge
);

   logic r_s0;
   logic r_s1;
   logic r_s2;

   // Shift the asynchronous level through the synchronizer chain.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s0 <= 1'b0;
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s0 <= i_async;
         r_s1 <= r_s0;
         r_s2 <= r_s1;
      end
   end

   assign o_edge = r_s1 ^ r_s2;

endmodule

// File: rtl/clk_monitor.sv
// Divided-clock monitor: measures each half-period of clk_in in clk cycles,
// declares lock after a run of in-tolerance half-periods and reports loss on
// a dead clock (timeout) or an off-frequency half-period.
//
// Handshake note: there is no valid/ready interface here. edge_stb and
// lost_stb are single-cycle strobes with no back-pressure; half_period,
// locked and err_cnt are levels valid every cycle. All FSM-driven outputs
// change on the same clock edge that raises edge_stb for the edge that
// caused them.
module clk_monitor
   import clk_mon_pkg::*;
#(
   parameter int HALF_PERIOD = 10,
   parameter int TOL         = 1,
   parameter int LOCK_COUNT  = 4,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_in,
   input  logic             clr,
   output logic             edge_stb,
   output logic [CNT_W-1:0] half_period,
   output logic             locked,
   output logic             lost_stb,
   output logic [ERR_W-1:0] err_cnt,
   output clk_state_e       dbg_state
);

   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

   // Comparison constants one bit wider than the counter so cnt+1 never wraps.
   localparam logic [CNT_W:0]    LP_HP      = (CNT_W+1)'(HALF_PERIOD);
   localparam logic [CNT_W:0]    LP_TOL     = (CNT_W+1)'(TOL);
   localparam logic [CNT_W-1:0]  LP_TO_M1   = CNT_W'(TIMEOUT - 1);
   localparam logic [GOOD_W-1:0] LP_LOCK_M1 = GOOD_W'(LOCK_COUNT - 1);

   logic              w_edge;
   logic [CNT_W:0]    w_meas;
   logic [CNT_W-1:0]  w_meas_sat;
   logic [CNT_W:0]    w_dev;
   logic              w_in_tol;
   logic              w_timeout;

   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_half_period;
   logic              r_edge_stb;
   clk_state_e        r_state;
   logic [GOOD_W-1:0] r_good_cnt;
   logic              r_locked;
   logic              r_lost_stb;
   logic [ERR_W-1:0]  r_err_cnt;

   clk_state_e        w_state_nxt;
   logic [GOOD_W-1:0] w_good_nxt;
   logic              w_err_inc;
   logic              w_lost_nxt;

   edge_sync u_edge_sync (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_async (clk_in),
      .o_edge  (w_edge)
   );

   // The half-period just ending is cnt+1 cycles long: cnt restarts at zero
   // in the cycle after the previous edge.
   assign w_meas     = {1'b0, r_cnt} + (CNT_W+1)'(1);
   assign w_meas_sat = w_meas[CNT_W] ? {CNT_W{1'b1}} : w_meas[CNT_W-1:0];

   // Absolute deviation from nominal, ordered so the subtraction never wraps.
   assign w_dev    = (w_meas >= LP_HP) ? (w_meas - LP_HP) : (LP_HP - w_meas);
   assign w_in_tol = (w_dev <= LP_TOL);

   // An edge arriving on the timeout cycle wins; it is judged instead.
   assign w_timeout = !w_edge && (r_cnt == LP_TO_M1);

   // Period counter, half-period capture and edge strobe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt         <= '0;
         r_half_period <= '0;
         r_edge_stb    <= 1'b0;
      end else begin
         r_edge_stb <= w_edge;
         if (w_edge) begin
            r_half_period <= w_meas_sat;
            r_cnt         <= '0;
         end else if (!(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Next-state logic: SEARCH discards its first edge, TRACK counts good
   // edges towards lock, LOCKED drops out on any bad edge or timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      w_err_inc   = 1'b0;
      w_lost_nxt  = 1'b0;
      case (r_state)
         SEARCH: begin
            if (w_edge) begin
               w_state_nxt = TRACK;
               w_good_nxt  = '0;
            end
         end
         TRACK: begin
            if (w_edge) begin
               if (w_in_tol) begin
                  w_good_nxt = r_good_cnt + GOOD_W'(1);
                  if (r_good_cnt == LP_LOCK_M1) begin
                     w_state_nxt = LOCKED;
                  end
               end else begin
                  w_good_nxt = '0;
                  w_err_inc  = 1'b1;
               end
            end else if (w_timeout) begin
               w_state_nxt = SEARCH;
            end
         end
         LOCKED: begin
            if (w_edge) begin
               if (!w_in_tol) begin
                  w_state_nxt = SEARCH;
                  w_err_inc   = 1'b1;
                  w_lost_nxt  = 1'b1;
               end
            end else if (w_timeout) begin
               w_state_nxt = SEARCH;
               w_lost_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = SEARCH;
            w_good_nxt  = '0;
         end
      endcase
   end

   // State register and FSM-driven outputs, updated alongside edge_stb.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= SEARCH;
         r_good_cnt <= '0;
         r_locked   <= 1'b0;
         r_lost_stb <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_nxt;
         r_locked   <= (w_state_nxt == LOCKED);
         r_lost_stb <= w_lost_nxt;
      end
   end

   // Saturating error counter; clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_err_cnt <= '0;
      end else if (clr) begin
         r_err_cnt <= '0;
      end else if (w_err_inc) begin
         r_err_cnt <= sat_inc(r_err_cnt);
      end
   end

   assign edge_stb    = r_edge_stb;
   assign half_period = r_half_period;
   assign locked      = r_locked;
   assign lost_stb    = r_lost_stb;
   assign err_cnt     = r_err_cnt;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: table of steady/alternating half-period
// patterns plus hand-written sequences for timeout, glitch, reset and clear.
module tb_clk_monitor;
   import clk_mon_pkg::*;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       clk_in = 1'b0;
   logic       clr    = 1'b0;
   logic       edge_stb;
   logic [7:0] half_period;
   logic       locked;
   logic       lost_stb;
   logic [7:0] err_cnt;
   clk_state_e dbg_state;

   clk_monitor #(
      .HALF_PERIOD (10),
      .TOL         (1),
      .LOCK_COUNT  (4),
      .TIMEOUT     (64),
      .CNT_W       (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_in      (clk_in),
      .clr         (clr),
      .edge_stb    (edge_stb),
      .half_period (half_period),
      .locked      (locked),
      .lost_stb    (lost_stb),
      .err_cnt     (err_cnt),
      .dbg_state   (dbg_state)
   );

   // Clock generation
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Values captured in the edge_stb cycle of the most recent half() call
   int s_hp;
   int s_locked;
   int s_err;
   int s_lost;
   int s_state;
   int lost_total;

   typedef struct {
      int a;
      int b;
      int n_edges;
      int exp_a;
      int exp_b;
      int lock_edge;
      int err_pe;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      lost_total += int'(lost_stb);
   endtask

   // Optionally toggle clk_in, then hold it for n cycles. The resulting
   // edge_stb must appear exactly in the third sampled cycle.
   task automatic half(input int n, input bit tog, input bit clr_edge);
      int pulses;
      int at;
      pulses = 0;
      at = -1;
      if (tog) clk_in = ~clk_in;
      for (int i = 0; i < n; i++) begin
         if (clr_edge && i == 2) clr = 1'b1;
         step();
         clr = 1'b0;
         if (edge_stb) begin
            pulses++;
            at = i;
         end
         if (i == 2) begin
            s_hp     = int'(half_period);
            s_locked = int'(locked);
            s_err    = int'(err_cnt);
            s_lost   = int'(lost_stb);
            s_state  = int'(dbg_state);
         end
      end
      chk("edge_stb_timing", int'(pulses == 1 && at == 2), 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_edge_stb"}, int'(edge_stb), 0);
      chk({tag, "_half_period"}, int'(half_period), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_lost_stb"}, int'(lost_stb), 0);
      chk({tag, "_err_cnt"}, int'(err_cnt), 0);
      chk({tag, "_state"}, int'(dbg_state), int'(SEARCH));
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      clk_in = 1'b0;
      clr    = 1'b0;
      step();
      check_zero("reset");
      step();
      reset = 1'b1;
      lost_total = 0;
   endtask

   initial begin
      int first_lost;
      int elapsed;
      int lk_at;
      int st_at;
      int prev_locked;
      int exp_hp;
      int exp_lk;

      vecs[0] = '{10, 10, 8, 10, 10, 5, 0};
      vecs[1] = '{9, 11, 8, 9, 11, 5, 0};
      vecs[2] = '{12, 12, 6, 12, 12, 0, 1};
      vecs[3] = '{11, 11, 7, 11, 11, 5, 0};
      vecs[4] = '{8, 8, 6, 8, 8, 0, 1};
      vecs[5] = '{9, 9, 6, 9, 9, 5, 0};

      // Table-driven patterns: edge k measures the hold of call k-1
      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int k = 1; k <= vecs[v].n_edges; k++) begin
            half((k % 2 == 1) ? vecs[v].a : vecs[v].b, 1'b1, 1'b0);
            exp_lk = (vecs[v].lock_edge != 0 && k >= vecs[v].lock_edge) ? 1 : 0;
            chk($sformatf("v%0d_e%0d_locked", v, k), s_locked, exp_lk);
            chk($sformatf("v%0d_e%0d_err", v, k), s_err,
                (k >= 2) ? (k - 1) * vecs[v].err_pe : 0);
            if (k >= 2) begin
               exp_hp = (k % 2 == 0) ? vecs[v].exp_a : vecs[v].exp_b;
               chk($sformatf("v%0d_e%0d_half_period", v, k), s_hp, exp_hp);
            end
         end
         chk($sformatf("v%0d_state", v), int'(dbg_state),
             (vecs[v].lock_edge != 0) ? int'(LOCKED) : int'(TRACK));
         chk($sformatf("v%0d_no_lost", v), lost_total, 0);
      end

      // Saturation of err_cnt with a constant 12-cycle half-period
      do_reset();
      for (int k = 1; k <= 300; k++) begin
         half(12, 1'b1, 1'b0);
         if (k == 255) chk("sat_e255_err", s_err, 254);
         if (k == 256) chk("sat_e256_err", s_err, 255);
      end
      chk("sat_e300_err", s_err, 255);
      chk("sat_locked", s_locked, 0);

      // Dead clock while locked: one lost_stb, 64 cycles after the last edge
      do_reset();
      for (int k = 1; k <= 6; k++) half(10, 1'b1, 1'b0);
      chk("to_locked_before", int'(locked), 1);
      lost_total  = 0;
      elapsed     = 7;
      first_lost  = -1;
      lk_at       = -1;
      st_at       = -1;
      prev_locked = int'(locked);
      for (int j = 0; j < 200; j++) begin
         step();
         elapsed++;
         if (lost_stb && first_lost < 0) begin
            first_lost = elapsed;
            lk_at      = int'(locked);
            st_at      = int'(dbg_state);
            chk("to_locked_prev_cycle", prev_locked, 1);
         end
         prev_locked = int'(locked);
      end
      chk("to_lost_offset", first_lost, 64);
      chk("to_lost_count", lost_total, 1);
      chk("to_locked_at_lost", lk_at, 0);
      chk("to_state_at_lost", st_at, int'(SEARCH));

      // One 13-cycle glitch while locked, then relock on the 5th edge after
      do_reset();
      for (int k = 1; k <= 6; k++) half(10, 1'b1, 1'b0);
      chk("gl_e6_locked", s_locked, 1);
      half(13, 1'b1, 1'b0);
      chk("gl_e7_locked", s_locked, 1);
      half(10, 1'b1, 1'b0);
      chk("gl_e8_lost", s_lost, 1);
      chk("gl_e8_locked", s_locked, 0);
      chk("gl_e8_err", s_err, 1);
      chk("gl_e8_half_period", s_hp, 13);
      chk("gl_e8_state", s_state, int'(SEARCH));
      for (int k = 9; k <= 13; k++) begin
         half(10, 1'b1, 1'b0);
         if (k == 9)  chk("gl_e9_state", s_state, int'(TRACK));
         if (k == 12) chk("gl_e12_locked", s_locked, 0);
      end
      chk("gl_e13_locked", s_locked, 1);
      chk("gl_e13_err", s_err, 1);
      chk("gl_lost_count", lost_total, 1);

      // Edge coinciding with the timeout cycle is judged, not timed out
      do_reset();
      for (int k = 1; k <= 6; k++) half(10, 1'b1, 1'b0);
      lost_total = 0;
      half(64, 1'b1, 1'b0);
      chk("co_e7_locked", s_locked, 1);
      half(10, 1'b1, 1'b0);
      chk("co_e8_err", s_err, 1);
      chk("co_e8_lost", s_lost, 1);
      chk("co_e8_half_period", s_hp, 64);
      chk("co_lost_count", lost_total, 1);

      // Reset while locked with clk_in high; the spurious edge is discarded
      do_reset();
      for (int k = 1; k <= 5; k++) half(10, 1'b1, 1'b0);
      chk("rl_locked", s_locked, 1);
      chk("rl_clk_in_high", int'(clk_in), 1);
      reset = 1'b0;
      step();
      check_zero("rl_mid");
      step();
      reset = 1'b1;
      half(10, 1'b0, 1'b0);
      chk("rl_e1_state", s_state, int'(TRACK));
      chk("rl_e1_locked", s_locked, 0);
      for (int k = 2; k <= 5; k++) begin
         half(10, 1'b1, 1'b0);
         if (k == 2) chk("rl_e2_half_period", s_hp, 10);
         if (k == 4) chk("rl_e4_locked", s_locked, 0);
      end
      chk("rl_e5_locked", s_locked, 1);

      // Clear coinciding with an out-of-tolerance edge wins
      do_reset();
      for (int k = 1; k <= 3; k++) half(12, 1'b1, 1'b0);
      chk("clr_e3_err", s_err, 2);
      half(12, 1'b1, 1'b1);
      chk("clr_e4_err", s_err, 0);
      half(12, 1'b1, 1'b0);
      chk("clr_e5_err", s_err, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time bound
   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
